// File: rtl/de_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : de_exec_pkg
// Brief   : Shared types and constants for the Decode/Execute execute unit.
// Revision: 1.0 - initial release
// ============================================================================
package de_exec_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    // Pass-through control bits, ordered as they travel down the pipe.
    typedef struct packed {
        logic wbs;
        logic wme;
        logic mm;
        logic wm;
        logic am;
        logic ni;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/de_execute_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : de_execute_unit_if
// Brief   : Decode->Execute request and Execute->Memory result handshakes.
// Revision: 1.0 - initial release
// ============================================================================
interface de_execute_unit_if #(
    parameter int unsigned WIDTH = de_exec_pkg::DEFAULT_WIDTH
) ();
    logic             de_valid;
    logic             de_ready;
    logic             wbs_in, wme_in, mm_in, wm_in, am_in, ni_in;
    logic [2:0]       ALUop_in;
    logic [WIDTH-1:0] srcA_in;
    logic [WIDTH-1:0] srcB_in;

    logic             em_valid;
    logic             em_ready;
    logic             wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
    logic [2:0]       ALUop_out;
    logic [WIDTH-1:0] alu_result;
    logic             z_flag;
    logic             n_flag;
    logic             busy;

    // Execute unit view
    modport slave (
        input  de_valid, wbs_in, wme_in, mm_in, wm_in, am_in, ni_in,
               ALUop_in, srcA_in, srcB_in, em_ready,
        output de_ready, em_valid, wbs_out, wme_out, mm_out, wm_out, am_out,
               ni_out, ALUop_out, alu_result, z_flag, n_flag, busy
    );

    // Decode / downstream view
    modport master (
        output de_valid, wbs_in, wme_in, mm_in, wm_in, am_in, ni_in,
               ALUop_in, srcA_in, srcB_in, em_ready,
        input  de_ready, em_valid, wbs_out, wme_out, mm_out, wm_out, am_out,
               ni_out, ALUop_out, alu_result, z_flag, n_flag, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Brief   : Shift-add multiplier, one multiplier bit per cycle, low WIDTH bits.
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int unsigned WIDTH = de_exec_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             last;

    assign last    = (cnt_q == CW'(WIDTH - 1));
    // Pulses in the cycle whose edge folds in the final bit.
    assign done    = run_q && last;
    assign product = prod_q;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            a_d    = a;
            b_d    = b;
            prod_d = '0;
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (b_q[0]) begin
                prod_d = prod_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/de_execute_unit.sv
`default_nettype none
// ============================================================================
// Module  : de_execute_unit
// Brief   : Execute stage: single-cycle ALU ops, iterative MUL, registered
//           result with valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module de_execute_unit #(
    parameter int unsigned WIDTH = de_exec_pkg::DEFAULT_WIDTH,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    de_execute_unit_if.slave bus
);
    import de_exec_pkg::*;

    exec_state_t      state_q, state_d;
    logic             em_valid_q, em_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
    ctrl_t            ctrl_out_q, ctrl_out_d;
    alu_op_t          op_out_q, op_out_d;
    ctrl_t            ctrl_mul_q, ctrl_mul_d;

    alu_op_t          op_in;
    ctrl_t            ctrl_in;
    logic             out_free;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_value;
    logic             load;
    logic [WIDTH-1:0] load_value;

    assign op_in   = alu_op_t'(bus.ALUop_in);
    assign ctrl_in = {bus.wbs_in, bus.wme_in, bus.mm_in, bus.wm_in, bus.am_in, bus.ni_in};

    // Output slot is free when empty or being consumed this edge.
    assign out_free     = !em_valid_q || bus.em_ready;
    assign bus.de_ready = !rst && (state_q == ST_IDLE) && out_free;
    assign accept       = bus.de_valid && bus.de_ready;
    assign mul_start    = accept && (op_in == OP_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.srcA_in),
        .b       (bus.srcB_in),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_value = '0;
        case (op_in)
            OP_ADD:  alu_value = bus.srcA_in + bus.srcB_in;
            OP_SUB:  alu_value = bus.srcA_in - bus.srcB_in;
            OP_AND:  alu_value = bus.srcA_in & bus.srcB_in;
            OP_OR:   alu_value = bus.srcA_in | bus.srcB_in;
            OP_XOR:  alu_value = bus.srcA_in ^ bus.srcB_in;
            OP_SHL:  alu_value = bus.srcA_in << bus.srcB_in[SHW-1:0];
            OP_SHR:  alu_value = bus.srcA_in >> bus.srcB_in[SHW-1:0];
            default: alu_value = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        em_valid_d = em_valid_q;
        result_d   = result_q;
        z_d        = z_q;
        n_d        = n_q;
        ctrl_out_d = ctrl_out_q;
        op_out_d   = op_out_q;
        ctrl_mul_d = ctrl_mul_q;
        load       = 1'b0;
        load_value = '0;

        if (em_valid_q && bus.em_ready) begin
            em_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_in == OP_MUL) begin
                        ctrl_mul_d = ctrl_in;
                        state_d    = ST_MUL;
                    end else begin
                        load       = 1'b1;
                        load_value = alu_value;
                        ctrl_out_d = ctrl_in;
                        op_out_d   = op_in;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_free) begin
                    load       = 1'b1;
                    load_value = mul_product;
                    ctrl_out_d = ctrl_mul_q;
                    op_out_d   = OP_MUL;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            em_valid_d = 1'b1;
            result_d   = load_value;
            z_d        = (load_value == '0);
            n_d        = load_value[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            em_valid_q <= 1'b0;
            result_q   <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            ctrl_out_q <= '0;
            op_out_q   <= OP_ADD;
            ctrl_mul_q <= '0;
        end else begin
            state_q    <= state_d;
            em_valid_q <= em_valid_d;
            result_q   <= result_d;
            z_q        <= z_d;
            n_q        <= n_d;
            ctrl_out_q <= ctrl_out_d;
            op_out_q   <= op_out_d;
            ctrl_mul_q <= ctrl_mul_d;
        end
    end

    assign bus.em_valid   = em_valid_q;
    assign bus.alu_result = result_q;
    assign bus.z_flag     = z_q;
    assign bus.n_flag     = n_q;
    assign bus.ALUop_out  = op_out_q;
    assign bus.wbs_out    = ctrl_out_q.wbs;
    assign bus.wme_out    = ctrl_out_q.wme;
    assign bus.mm_out     = ctrl_out_q.mm;
    assign bus.wm_out     = ctrl_out_q.wm;
    assign bus.am_out     = ctrl_out_q.am;
    assign bus.ni_out     = ctrl_out_q.ni;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_de_execute_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_de_execute_unit
// Brief   : Directed scenarios plus randomized traffic against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_de_execute_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    de_execute_unit_if #(.WIDTH(16)) bus ();

    de_execute_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [5:0] ctrl_o;
    assign ctrl_o = {bus.wbs_out, bus.wme_out, bus.mm_out, bus.wm_out, bus.am_out, bus.ni_out};

    typedef struct {
        logic [2:0]  op;
        logic [15:0] res;
        logic [5:0]  ctrl;
    } txn_t;

    txn_t sb[$];

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] full;
        int          sh;
        sh = int'(b % 16);
        case (op)
            3'd0: full = a + b;
            3'd1: full = a - b;
            3'd2: full = a & b;
            3'd3: full = a | b;
            3'd4: full = a ^ b;
            3'd5: full = a * (2 ** sh);
            3'd6: full = a / (2 ** sh);
            default: full = a * b;
        endcase
        return full[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [5:0] ctrl);
        bus.de_valid = v;
        bus.ALUop_in = op;
        bus.srcA_in  = a;
        bus.srcB_in  = b;
        {bus.wbs_in, bus.wme_in, bus.mm_in, bus.wm_in, bus.am_in, bus.ni_in} = ctrl;
    endtask

    task automatic test_reset();
        repeat (3) step();
        tests_run++;
        if ({bus.em_valid, bus.busy, bus.de_ready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctl: valid/busy/ready=%b required 000",
                     {bus.em_valid, bus.busy, bus.de_ready});
        end
        tests_run++;
        if ({bus.alu_result, ctrl_o, bus.z_flag, bus.n_flag} !== 24'h0) begin
            tests_failed++;
            $display("FAIL reset_data: result=%h ctrl=%b required 0", bus.alu_result, ctrl_o);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.de_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: de_ready=%b required 1", bus.de_ready);
        end
    endtask

    task automatic test_add();
        bus.em_ready = 1'b1;
        drive_op(1'b1, 3'd0, 16'h0006, 16'h0007, 6'b101111);
        step();
        bus.de_valid = 1'b0;
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.z_flag, bus.n_flag, bus.ALUop_out} !==
            {1'b1, 16'h000D, 1'b0, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL add_result: valid=%b res=%h z=%b n=%b op=%0d required 1 000d 0 0 0",
                     bus.em_valid, bus.alu_result, bus.z_flag, bus.n_flag, bus.ALUop_out);
        end
        tests_run++;
        if (ctrl_o !== 6'b101111) begin
            tests_failed++;
            $display("FAIL add_ctrl: ctrl=%b required 101111", ctrl_o);
        end
        step();
        tests_run++;
        if (bus.em_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_retire: em_valid=%b required 0", bus.em_valid);
        end
    endtask

    task automatic test_back_to_back();
        int bad_ready = 0;
        bus.em_ready = 1'b1;
        drive_op(1'b1, 3'd1, 16'h0001, 16'h0005, 6'b000000);
        #1;
        if (bus.de_ready !== 1'b1) bad_ready++;
        step();
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.n_flag, bus.z_flag} !== {1'b1, 16'hFFFC, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_sub: valid=%b res=%h n=%b z=%b required 1 fffc 1 0",
                     bus.em_valid, bus.alu_result, bus.n_flag, bus.z_flag);
        end
        drive_op(1'b1, 3'd2, 16'hFFFF, 16'h0000, 6'b010000);
        #1;
        if (bus.de_ready !== 1'b1) bad_ready++;
        step();
        bus.de_valid = 1'b0;
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.z_flag, bus.n_flag} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_and: valid=%b res=%h z=%b n=%b required 1 0000 1 0",
                     bus.em_valid, bus.alu_result, bus.z_flag, bus.n_flag);
        end
        if (bus.de_ready !== 1'b1) bad_ready++;
        tests_run++;
        if (bad_ready !== 0) begin
            tests_failed++;
            $display("FAIL b2b_ready: de_ready low in %0d samples required 0", bad_ready);
        end
        step();
    endtask

    task automatic test_mul();
        int bad = 0;
        bus.em_ready = 1'b1;
        drive_op(1'b1, 3'd7, 16'h0003, 16'h0005, 6'b110011);
        step();
        bus.de_valid = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if ({bus.busy, bus.de_ready, bus.em_valid} !== 3'b100) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL mul_busy_window: %0d bad cycles required 0", bad);
        end
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.ALUop_out, ctrl_o, bus.busy} !==
            {1'b1, 16'h000F, 3'd7, 6'b110011, 1'b0}) begin
            tests_failed++;
            $display("FAIL mul_result: valid=%b res=%h op=%0d ctrl=%b busy=%b required 1 000f 7 110011 0",
                     bus.em_valid, bus.alu_result, bus.ALUop_out, ctrl_o, bus.busy);
        end
        step();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.em_ready = 1'b0;
        drive_op(1'b1, 3'd0, 16'h1234, 16'h0001, 6'b000001);
        step();
        drive_op(1'b1, 3'd4, 16'hF0F0, 16'h0FF0, 6'b100000);
        for (int i = 0; i < 4; i++) begin
            #1;
            if ({bus.em_valid, bus.alu_result, bus.de_ready, ctrl_o} !==
                {1'b1, 16'h1235, 1'b0, 6'b000001}) bad++;
            step();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
        end
        bus.em_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.de_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_ready: de_ready=%b required 1", bus.de_ready);
        end
        step();
        bus.de_valid = 1'b0;
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.n_flag, ctrl_o} !== {1'b1, 16'hFF00, 1'b1, 6'b100000}) begin
            tests_failed++;
            $display("FAIL bp_next_load: valid=%b res=%h n=%b ctrl=%b required 1 ff00 1 100000",
                     bus.em_valid, bus.alu_result, bus.n_flag, ctrl_o);
        end
        step();
    endtask

    task automatic test_shift();
        bus.em_ready = 1'b1;
        drive_op(1'b1, 3'd5, 16'h0001, 16'h0013, 6'b000000);
        step();
        tests_run++;
        if (bus.alu_result !== 16'h0008) begin
            tests_failed++;
            $display("FAIL shl: res=%h required 0008", bus.alu_result);
        end
        drive_op(1'b1, 3'd6, 16'h8000, 16'h000F, 6'b111111);
        step();
        bus.de_valid = 1'b0;
        tests_run++;
        if ({bus.alu_result, bus.n_flag} !== {16'h0001, 1'b0}) begin
            tests_failed++;
            $display("FAIL shr: res=%h n=%b required 0001 0", bus.alu_result, bus.n_flag);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        int bad = 0;
        bus.em_ready = 1'b1;
        drive_op(1'b1, 3'd7, 16'h1234, 16'h0003, 6'b101010);
        step();
        bus.de_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.em_valid, bus.busy, bus.de_ready, bus.alu_result, ctrl_o, bus.ALUop_out} !== 29'h0) begin
            tests_failed++;
            $display("FAIL midmul_reset: valid=%b busy=%b ready=%b res=%h ctrl=%b required all 0",
                     bus.em_valid, bus.busy, bus.de_ready, bus.alu_result, ctrl_o);
        end
        step();
        rst = 1'b0;
        drive_op(1'b1, 3'd0, 16'h0002, 16'h0003, 6'b000000);
        step();
        bus.de_valid = 1'b0;
        tests_run++;
        if ({bus.em_valid, bus.alu_result, bus.ALUop_out} !== {1'b1, 16'h0005, 3'd0}) begin
            tests_failed++;
            $display("FAIL midmul_add: valid=%b res=%h op=%0d required 1 0005 0",
                     bus.em_valid, bus.alu_result, bus.ALUop_out);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.em_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL midmul_stale: %0d cycles with stale activity required 0", bad);
        end
    endtask

    task automatic test_random();
        txn_t        t;
        logic        acc;
        logic        cons;
        logic [42:0] obs;
        logic [42:0] expv;
        int          drain;
        sb.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            t.op   = 3'($urandom_range(0, 7));
            t.ctrl = 6'($urandom);
            drive_op(($urandom_range(0, 3) != 0), t.op, 16'($urandom), 16'($urandom), t.ctrl);
            bus.em_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (bus.em_valid) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_unexpected: em_valid=1 res=%h required no result", bus.alu_result);
                end else begin
                    obs  = {bus.ALUop_out, bus.alu_result, bus.z_flag, bus.n_flag, ctrl_o, 16'h0};
                    expv = {sb[0].op, sb[0].res, (sb[0].res == 16'h0), sb[0].res[15], sb[0].ctrl, 16'h0};
                    if (obs !== expv) begin
                        tests_failed++;
                        $display("FAIL rnd_data: op/res/z/n/ctrl=%h required %h", obs, expv);
                    end
                end
            end
            acc  = bus.de_valid && bus.de_ready;
            cons = bus.em_valid && bus.em_ready;
            t.res = ref_alu(bus.ALUop_in, bus.srcA_in, bus.srcB_in);
            t.op  = bus.ALUop_in;
            step();
            if (cons && sb.size() > 0) void'(sb.pop_front());
            if (acc) sb.push_back(t);
        end
        bus.de_valid = 1'b0;
        bus.em_ready = 1'b1;
        drain = 0;
        while (sb.size() > 0 && drain < 60) begin
            #1;
            if (bus.em_valid) begin
                tests_run++;
                if (bus.alu_result !== sb[0].res) begin
                    tests_failed++;
                    $display("FAIL rnd_drain: res=%h required %h", bus.alu_result, sb[0].res);
                end
                cons = 1'b1;
            end else begin
                cons = 1'b0;
            end
            step();
            if (cons) void'(sb.pop_front());
            drain++;
        end
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL rnd_timeout: %0d results outstanding required 0", sb.size());
        end
    endtask

    initial begin
        drive_op(1'b0, 3'd0, 16'h0, 16'h0, 6'b0);
        bus.em_ready = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_shift();
        test_reset_mid_mul();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
